// File: rtl/sync_frame_tx_if.sv
// Handshake and serial-line bundle for sync_frame_tx.
// The master side requests frames; the slave side (the transmitter) drives the line.
interface sync_frame_tx_if #(
  parameter int unsigned DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] data;
  logic              out;
  logic              ready;
  logic              busy;
  logic              done;

  modport master (output start, data, input out, ready, busy, done);
  modport slave  (input start, data, output out, ready, busy, done);
endinterface

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: "001" preamble, MSB-first payload, parity, stop bit.
// Moore FSM; out/ready/busy/done are registered alongside the state.
module sync_frame_tx #(
  parameter int unsigned DATA_W     = 8,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic          clk,
  input  logic          reset_n,
  sync_frame_tx_if.slave tx
);

  localparam int unsigned CntW = $clog2(DATA_W);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StPre0   = 3'd1,
    StPre1   = 3'd2,
    StPre2   = 3'd3,
    StData   = 3'd4,
    StParity = 3'd5,
    StStop   = 3'd6
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [CntW-1:0]   cnt_q;
  logic              parity_q;
  logic              out_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;

  // Outputs are assigned for the state being entered, so they line up with state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      cnt_q    <= '0;
      parity_q <= 1'b0;
      out_q    <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (tx.start) begin
            state_q  <= StPre0;
            shreg_q  <= tx.data;
            parity_q <= (^tx.data) ^ PARITY_ODD;
            out_q    <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
          end
        end
        StPre0: begin
          state_q <= StPre1;
          out_q   <= 1'b0;
        end
        StPre1: begin
          state_q <= StPre2;
          out_q   <= 1'b1;
        end
        StPre2: begin
          state_q <= StData;
          cnt_q   <= '0;
          out_q   <= shreg_q[DATA_W-1];
        end
        StData: begin
          shreg_q <= shreg_q << 1;
          if (cnt_q == CntLast) begin
            state_q <= StParity;
            cnt_q   <= '0;
            out_q   <= parity_q;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
            out_q <= shreg_q[DATA_W-2];
          end
        end
        StParity: begin
          state_q <= StStop;
          out_q   <= 1'b1;
          done_q  <= 1'b1;
        end
        StStop: begin
          state_q <= StIdle;
          out_q   <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          // Unused encoding: fall back to a clean idle.
          state_q <= StIdle;
          cnt_q   <= '0;
          out_q   <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx.out   = out_q;
  assign tx.ready = ready_q;
  assign tx.busy  = busy_q;
  assign tx.done  = done_q;

endmodule
